// File: rtl/hex_display_pkg.sv
// Shared types and segment patterns for the hex display scanner.
// Patterns are active-high {a,b,c,d,e,f,g}; bit 6 = a.
package hex_display_pkg;

  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG_OFF = 7'h7F;

  localparam seg7_t SEG_LUT [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

endpackage

// File: rtl/hex_display_scan_lut.sv
// Nibble to active-high 7-segment pattern.
// Pure combinational table lookup.
module hex7seg_lut
  import hex_display_pkg::*;
(
  input  logic [3:0] nib_i,
  output seg7_t      seg_o
);

  assign seg_o = SEG_LUT[nib_i];

endmodule

// File: rtl/hex_display_scan.sv
// Time-multiplexed driver for common-anode 7-segment digits.
// Shadowed inputs, blank window, enables, dp, leading-zero blanking.
module hex_display_scan
  import hex_display_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    lz_blank,
  output logic [6:0]              seg_n,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    slot_tick
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  logic [4*NUM_DIGITS-1:0] value_q;
  logic [NUM_DIGITS-1:0]   dp_q;
  logic [NUM_DIGITS-1:0]   en_q;
  logic                    lz_q;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;

  seg7_t                 seg_n_q, seg_n_d;
  logic                  dp_n_q, dp_n_d;
  logic [NUM_DIGITS-1:0] an_n_q, an_n_d;

  logic [NUM_DIGITS:0]   upper_zero;
  logic [NUM_DIGITS-1:0] an_sel;
  logic [3:0]            sel_nib;
  logic                  sel_en;
  logic                  sel_dp;
  logic                  sel_uz;
  logic                  zero_blank;
  logic                  in_blank;
  seg7_t                 pat;

  // Shadow registers: captured on load, used from the next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= '0;
      dp_q    <= '0;
      en_q    <= '1;
      lz_q    <= 1'b0;
    end else if (load) begin
      value_q <= value;
      dp_q    <= dp_in;
      en_q    <= digit_en;
      lz_q    <= lz_blank;
    end
  end

  // Prescaler and digit index next state.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
  end

  // Prescaler and digit index registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  assign slot_tick = (cnt_q == CNT_LAST);

  // Per-digit flag: this nibble and all above it are zero.
  always_comb begin
    upper_zero = '0;
    upper_zero[NUM_DIGITS] = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      upper_zero[i] = upper_zero[i+1] & (value_q[4*i +: 4] == 4'h0);
    end
  end

  // Select the current digit's nibble and attributes.
  always_comb begin
    an_sel  = '0;
    sel_nib = 4'h0;
    sel_en  = 1'b0;
    sel_dp  = 1'b0;
    sel_uz  = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (IW'(i) == idx_q) begin
        an_sel[i] = 1'b1;
        sel_nib   = value_q[4*i +: 4];
        sel_en    = en_q[i];
        sel_dp    = dp_q[i];
        sel_uz    = upper_zero[i];
      end
    end
  end

  hex7seg_lut u_lut (
    .nib_i (sel_nib),
    .seg_o (pat)
  );

  assign zero_blank = lz_q && (idx_q != '0) && sel_uz;
  assign in_blank   = int'(cnt_q) < BLANK_CYCLES;

  // Next display outputs from the current slot state.
  always_comb begin
    seg_n_d = SEG_OFF;
    dp_n_d  = 1'b1;
    an_n_d  = '1;
    if (!in_blank && sel_en) begin
      dp_n_d = ~sel_dp;
      if (zero_blank) begin
        if (sel_dp) an_n_d = ~an_sel;
      end else begin
        an_n_d  = ~an_sel;
        seg_n_d = ~pat;
      end
    end
  end

  // Registered pin drivers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_n_q <= SEG_OFF;
      dp_n_q  <= 1'b1;
      an_n_q  <= '1;
    end else begin
      seg_n_q <= seg_n_d;
      dp_n_q  <= dp_n_d;
      an_n_q  <= an_n_d;
    end
  end

  assign seg_n = seg_n_q;
  assign dp_n  = dp_n_q;
  assign an_n  = an_n_q;

endmodule

// File: tb/tb_hex_display_scan.sv
// Scoreboard bench for hex_display_scan.
// Model works from elapsed cycles and plain arithmetic.
module tb_hex_display_scan;

  localparam int N = 4;
  localparam int R = 4;
  localparam int B = 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load = 1'b0;
  logic [15:0]   value = '0;
  logic [3:0]    dp_in = '0;
  logic [3:0]    digit_en = '0;
  logic          lz_blank = 1'b0;
  logic [6:0]    seg_n;
  logic          dp_n;
  logic [3:0]    an_n;
  logic          slot_tick;

  hex_display_scan #(
    .NUM_DIGITS   (N),
    .REFRESH_DIV  (R),
    .BLANK_CYCLES (B)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .value     (value),
    .dp_in     (dp_in),
    .digit_en  (digit_en),
    .lz_blank  (lz_blank),
    .seg_n     (seg_n),
    .dp_n      (dp_n),
    .an_n      (an_n),
    .slot_tick (slot_tick)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       tick;
  } obs_t;

  localparam obs_t DARK = '{7'h7F, 1'b1, 4'hF, 1'b0};

  logic [6:0] pat [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  obs_t q[$];
  int   vectors = 0;
  int   miscompares = 0;

  int          k;
  logic [15:0] m_val;
  logic [3:0]  m_dp;
  logic [3:0]  m_en;
  logic        m_lz;
  obs_t        e;

  function automatic obs_t expect_disp(int c, int d);
    obs_t o;
    int   nib;
    bit   lead0;
    o = DARK;
    if (c < B) return o;
    if (!m_en[d]) return o;
    nib   = int'((m_val >> (4 * d)) & 16'hF);
    lead0 = m_lz && d > 0 && ((m_val >> (4 * d)) == 16'h0);
    o.dp  = ~m_dp[d];
    if (lead0) begin
      if (m_dp[d]) o.an = ~(4'b0001 << d);
    end else begin
      o.an  = ~(4'b0001 << d);
      o.seg = ~pat[nib];
    end
    return o;
  endfunction

  // Reference model: k counts cycles since reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k     = 0;
      m_val = '0;
      m_dp  = '0;
      m_en  = '1;
      m_lz  = 1'b0;
      q.delete();
      q.push_back(DARK);
    end else begin
      e = expect_disp(k % R, (k / R) % N);
      if (load) begin
        m_val = value;
        m_dp  = dp_in;
        m_en  = digit_en;
        m_lz  = lz_blank;
      end
      k++;
      e.tick = ((k % R) == R - 1);
      q.push_back(e);
    end
  end

  // Monitor: compare every presented output cycle.
  always @(negedge clk) begin
    obs_t exp_o;
    obs_t act;
    if (q.size() != 0) begin
      exp_o = q.pop_front();
      act   = '{seg_n, dp_n, an_n, slot_tick};
      vectors++;
      if (act !== exp_o) begin
        miscompares++;
        $display("FAIL outputs t=%0t got seg=%b dp=%b an=%b tick=%b want seg=%b dp=%b an=%b tick=%b",
                 $time, act.seg, act.dp, act.an, act.tick,
                 exp_o.seg, exp_o.dp, exp_o.an, exp_o.tick);
      end
      vectors++;
      if ($countones(~an_n) > 1) begin
        miscompares++;
        $display("FAIL onehot t=%0t got an=%b want at most one low", $time, an_n);
      end
    end
  end

  task automatic do_load(input logic [15:0] v, input logic [3:0] dp,
                         input logic [3:0] en, input logic lz);
    @(negedge clk);
    load     = 1'b1;
    value    = v;
    dp_in    = dp;
    digit_en = en;
    lz_blank = lz;
    @(negedge clk);
    load     = 1'b0;
    value    = 16'($urandom);
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    bit found;
    rst_n = 1'b0;
    run(3);
    rst_n = 1'b1;
    run(8);

    do_load(16'h12AF, 4'h0, 4'hF, 1'b0);
    run(16);

    for (int n = 0; n < 16; n++) begin
      do_load(16'(n), 4'h0, 4'hF, 1'b0);
      run(6);
    end

    do_load(16'h0030, 4'h0, 4'hF, 1'b1);
    run(16);
    do_load(16'h0000, 4'h0, 4'hF, 1'b1);
    run(16);
    do_load(16'h0000, 4'b1100, 4'hF, 1'b1);
    run(16);

    do_load(16'h5555, 4'b0001, 4'b1010, 1'b0);
    run(16);
    do_load(16'h5555, 4'b0001, 4'b1111, 1'b0);
    run(16);

    for (int i = 0; i < 30; i++) begin
      do_load(16'($urandom), 4'($urandom), 4'($urandom), 1'($urandom));
      run(int'($urandom_range(0, 9)));
    end

    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if ((k % R) == 1 && ((k / R) % N) == 2) found = 1'b1;
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("FAIL slot2_wait got timeout want digit 2 slot");
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({seg_n, dp_n, an_n, slot_tick} !== DARK) begin
      miscompares++;
      $display("FAIL async_reset got seg=%b dp=%b an=%b tick=%b want dark",
               seg_n, dp_n, an_n, slot_tick);
    end
    run(2);
    rst_n = 1'b1;
    run(20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
